// File: rtl/guided_play_sequencer.sv
// Guided-play lesson sequencer: steps through a song's notes from ROM and judges each key press.
// Optional hit/miss score counters are generated when GUIDED_SCORE_EN is defined.
module guided_play_sequencer #(
    parameter int NOTES_PER_SONG = 9,
    parameter int NUM_SONGS      = 4,
    parameter int ERR_CYCLES     = 16
) (
    input  logic                                                clk_in,
    input  logic                                                rst_in,
    input  logic [7:0]                                          keys_in,
    input  logic                                                trigger,
    input  logic                                                start,
    input  logic                                                abort,
    input  logic [2:0]                                          rom_data,
    output logic [$clog2(NUM_SONGS)+$clog2(NOTES_PER_SONG)-1:0] rom_addr,
    output logic [$clog2(NUM_SONGS)-1:0]                        song_address,
    output logic [$clog2(NOTES_PER_SONG)-1:0]                   note_index,
    output logic [2:0]                                          expected_note,
    output logic [2:0]                                          key_played,
    output logic                                                correct_pulse,
    output logic                                                wrong_pulse,
    output logic                                                err_active,
    output logic                                                song_done,
`ifdef GUIDED_SCORE_EN
    output logic [7:0]                                          hit_count,
    output logic [7:0]                                          miss_count,
`endif
    output logic                                                busy
);

    localparam int NW = $clog2(NOTES_PER_SONG);
    localparam int SW = $clog2(NUM_SONGS);
    localparam int CW = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;

    localparam logic [NW-1:0] LAST_NOTE = NW'(NOTES_PER_SONG - 1);
    localparam logic [SW-1:0] LAST_SONG = SW'(NUM_SONGS - 1);
    localparam logic [CW-1:0] ERR_LOAD  = CW'(ERR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_KEY,
        JUDGE,
        ERR_HOLD,
        DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [NW-1:0] note_reg, note_next;
    logic [SW-1:0] song_reg, song_next;
    logic [2:0]    exp_reg, exp_next;
    logic [2:0]    key_reg, key_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [7:0]    keys_prev_reg;
    logic          correct_reg, correct_next;
    logic          wrong_reg, wrong_next;
    logic          done_reg, done_next;
    logic          err_reg;

    logic [7:0]    edges;
    logic [2:0]    win_idx;

    // Rising edges only exist on sample strobes; the lowest key index wins.
    assign edges = trigger ? (keys_in & ~keys_prev_reg) : 8'h00;

    always_comb begin
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (edges[i]) win_idx = 3'(i);
        end
    end

    always_comb begin
        state_next   = state_reg;
        note_next    = note_reg;
        song_next    = song_reg;
        exp_next     = exp_reg;
        key_next     = key_reg;
        cnt_next     = cnt_reg;
        correct_next = 1'b0;
        wrong_next   = 1'b0;
        done_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                    note_next  = '0;
                end
            end
            FETCH: begin
                state_next = WAIT_KEY;
                exp_next   = rom_data;
            end
            WAIT_KEY: begin
                if (|edges) begin
                    key_next   = win_idx;
                    state_next = JUDGE;
                end
            end
            JUDGE: begin
                if (key_reg == exp_reg) begin
                    correct_next = 1'b1;
                    if (note_reg == LAST_NOTE) begin
                        state_next = DONE;
                    end else begin
                        note_next  = note_reg + NW'(1);
                        state_next = FETCH;
                    end
                end else begin
                    wrong_next = 1'b1;
                    cnt_next   = ERR_LOAD;
                    state_next = ERR_HOLD;
                end
            end
            ERR_HOLD: begin
                if (cnt_reg == '0) state_next = WAIT_KEY;
                else               cnt_next   = cnt_reg - CW'(1);
            end
            DONE: begin
                done_next  = 1'b1;
                note_next  = '0;
                song_next  = (song_reg == LAST_SONG) ? '0 : song_reg + SW'(1);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides everything but keeps the song selection and latched hint.
        if (abort) begin
            state_next   = IDLE;
            note_next    = '0;
            song_next    = song_reg;
            exp_next     = exp_reg;
            key_next     = key_reg;
            cnt_next     = '0;
            correct_next = 1'b0;
            wrong_next   = 1'b0;
            done_next    = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg     <= IDLE;
            note_reg      <= '0;
            song_reg      <= '0;
            exp_reg       <= '0;
            key_reg       <= '0;
            cnt_reg       <= '0;
            keys_prev_reg <= '0;
            correct_reg   <= 1'b0;
            wrong_reg     <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            note_reg    <= note_next;
            song_reg    <= song_next;
            exp_reg     <= exp_next;
            key_reg     <= key_next;
            cnt_reg     <= cnt_next;
            correct_reg <= correct_next;
            wrong_reg   <= wrong_next;
            done_reg    <= done_next;
            err_reg     <= (state_next == ERR_HOLD);
            if (trigger) keys_prev_reg <= keys_in;
        end
    end

`ifdef GUIDED_SCORE_EN
    logic [7:0] hit_reg, miss_reg;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_reg  <= '0;
            miss_reg <= '0;
        end else if (state_reg == IDLE && start && !abort) begin
            hit_reg  <= '0;
            miss_reg <= '0;
        end else begin
            if (correct_next && hit_reg != 8'hFF) hit_reg  <= hit_reg + 8'd1;
            if (wrong_next && miss_reg != 8'hFF)  miss_reg <= miss_reg + 8'd1;
        end
    end

    assign hit_count  = hit_reg;
    assign miss_count = miss_reg;
`endif

    assign rom_addr      = {song_reg, note_reg};
    assign song_address  = song_reg;
    assign note_index    = note_reg;
    assign expected_note = exp_reg;
    assign key_played    = key_reg;
    assign correct_pulse = correct_reg;
    assign wrong_pulse   = wrong_reg;
    assign err_active    = err_reg;
    assign song_done     = done_reg;
    assign busy          = (state_reg != IDLE);

endmodule
